// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: keeps at most one request in flight to instruction
// memory and fills a two-entry buffer that decode drains. Redirects flush the
// buffer and restart fetch. Halt stops fetching until reset.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | may issue a request for fetch_pc when the buffer has room
// WAIT_RESP | request accepted; next response is written to the buffer tail
// DRAIN     | request accepted but redirected; next response is dropped
// HALTED    | fetch stopped for good; every input is ignored until reset
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        is_halted
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_RESP = 2'd1,
    S_DRAIN     = 2'd2,
    S_HALTED    = 2'd3
  } state_e;

  localparam logic [1:0] BUF_FULL = 2'(BUF_DEPTH);

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        started_q;

  logic [1:0]  count_q, count_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [31:0] buf_inst_q [2];
  logic [31:0] buf_pc_q   [2];

  logic        req_fire;
  logic        flush;
  logic        push;
  logic        pop;
  logic [31:0] redirect_pc_aligned;
  logic        unused_redirect_lsb;

  assign redirect_pc_aligned = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Request depends only on registered state, never on redirect/inst_ready.
  // started_q holds the first request back until one edge after reset release,
  // so a stale response landing right after release finds the unit idle.
  assign imem_req_valid = started_q && (state_q == S_IDLE) && (count_q < BUF_FULL);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign inst_valid = (count_q != 2'd0);
  assign inst       = buf_inst_q[rd_ptr_q];
  assign inst_pc    = buf_pc_q[rd_ptr_q];
  assign is_halted  = (state_q == S_HALTED);

  // Pop is suppressed on the flush edge so a redirect/halt wins over decode.
  assign pop = inst_valid && inst_ready && !flush;

  // Next-state, fetch PC and buffer push/flush decisions.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    flush      = 1'b0;
    push       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (halt) begin
          state_d = S_HALTED;
          flush   = 1'b1;
        end else if (redirect_valid) begin
          flush      = 1'b1;
          fetch_pc_d = redirect_pc_aligned;
          // The request was already visible to memory; if it was taken on
          // this same edge its response still has to be soaked up.
          state_d    = req_fire ? S_DRAIN : S_IDLE;
        end else if (req_fire) begin
          state_d    = S_WAIT_RESP;
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
        end
      end
      S_WAIT_RESP: begin
        if (halt) begin
          state_d = S_HALTED;
          flush   = 1'b1;
        end else if (redirect_valid) begin
          flush      = 1'b1;
          fetch_pc_d = redirect_pc_aligned;
          state_d    = imem_resp_valid ? S_IDLE : S_DRAIN;
        end else if (imem_resp_valid) begin
          push    = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (halt) begin
          state_d = S_HALTED;
          flush   = 1'b1;
        end else if (redirect_valid) begin
          flush      = 1'b1;
          fetch_pc_d = redirect_pc_aligned;
          // A response on the same edge is the one being drained.
          state_d    = imem_resp_valid ? S_IDLE : S_DRAIN;
        end else if (imem_resp_valid) begin
          state_d = S_IDLE;
        end
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Buffer occupancy and pointer bookkeeping.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      if (push && !pop)      count_d = count_q + 2'd1;
      else if (pop && !push) count_d = count_q - 2'd1;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      started_q  <= 1'b0;
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      started_q  <= 1'b1;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Buffer storage: returned word tagged with the PC it was fetched from.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_inst_q[0] <= 32'd0;
      buf_inst_q[1] <= 32'd0;
      buf_pc_q[0]   <= 32'd0;
      buf_pc_q[1]   <= 32'd0;
    end else if (push) begin
      buf_inst_q[wr_ptr_q] <= imem_resp_data;
      buf_pc_q[wr_ptr_q]   <= req_pc_q;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: memory and decode models drive the DUT, a
// scoreboard holds the instruction stream decode should see (sequential from
// reset or from the latest redirect), and a monitor checks every consumption.
module tb_inst_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        is_halted;

  inst_fetch_unit #(.RESET_PC(RPC), .BUF_DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .is_halted      (is_halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] cons_log[$];
  logic [31:0] req_log[$];
  int          total = 0;
  int          bad = 0;
  int          consumed = 0;
  bit          mem_rdy_rand = 1'b0;
  bit          keep_stale = 1'b0;
  bit          halted_model = 1'b0;
  int          mem_lat = 1;
  int          dec_mode = 0;
  logic [31:0] gen_pc;

  bit          pending = 1'b0;
  bit          prev_wait = 1'b0;
  logic [31:0] pend_addr;
  logic [31:0] prev_addr;
  int          pend_cnt = 0;

  int          rb, rb2, base, c0;
  logic [31:0] rpc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_cons(input int idx, input logic [31:0] exp, input string name);
    if (cons_log.size() > idx) check32(name, cons_log[idx], exp);
    else begin
      total++;
      bad++;
      $display("FAIL %s: no instruction delivered, expected pc %h", name, exp);
    end
  endtask

  task automatic check_req(input int idx, input logic [31:0] exp, input string name);
    if (req_log.size() > idx) check32(name, req_log[idx], exp);
    else begin
      total++;
      bad++;
      $display("FAIL %s: no request seen, expected addr %h", name, exp);
    end
  endtask

  // Expected stream: sequential words from the last reset/redirect target.
  task automatic topup();
    if (!halted_model) begin
      while (exp_q.size() < 16) begin
        exp_q.push_back('{pc: gen_pc, word: mem_word(gen_pc)});
        gen_pc = gen_pc + 32'd4;
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      topup();
    end
  endtask

  task automatic redirect_now(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    exp_q.delete();
    gen_pc = {pc[31:2], 2'b00};
    topup();
    @(negedge clk);
    redirect_valid = 1'b0;
    topup();
  endtask

  task automatic wait_req_addr(input logic [31:0] a, input int start, input int lim);
    for (int c = 0; c < lim; c++) begin
      @(negedge clk);
      topup();
      if (req_log.size() > start && req_log[req_log.size()-1] == a) return;
    end
    total++;
    bad++;
    $display("FAIL wait_req: no request for addr %h within %0d cycles", a, lim);
  endtask

  task automatic do_reset(input bit chk);
    @(negedge clk);
    reset          = 1'b0;
    redirect_valid = 1'b0;
    halt           = 1'b0;
    halted_model   = 1'b0;
    exp_q.delete();
    gen_pc = RPC;
    topup();
    @(negedge clk);
    #3;
    if (chk) begin
      check32("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
      check32("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
      check32("rst_is_halted", {31'd0, is_halted}, 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    topup();
    if (chk) begin
      #3;
      check32("req_before_first_edge", {31'd0, imem_req_valid}, 32'd0);
      @(negedge clk);
      topup();
      #3;
      check32("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
      check32("first_req_addr", imem_req_addr, RPC);
    end
  endtask

  // Memory model: single-entry request/response with configurable latency.
  initial begin
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'd0;
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        imem_resp_valid = 1'b0;
        imem_req_ready  = 1'b0;
        if (!keep_stale) pending = 1'b0;
        prev_wait = 1'b0;
      end else begin
        if (prev_wait) begin
          check32("req_hold_valid", {31'd0, imem_req_valid}, 32'd1);
          check32("req_hold_addr", imem_req_addr, prev_addr);
        end
        imem_resp_valid = 1'b0;
        if (pending) begin
          if (keep_stale || pend_cnt == 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(pend_addr);
            pending         = 1'b0;
          end else begin
            pend_cnt--;
          end
        end
        if (imem_req_valid) check32("one_outstanding", {31'd0, pending}, 32'd0);
        imem_req_ready = mem_rdy_rand ? ($urandom_range(0, 9) < 7) : 1'b1;
        if (imem_req_valid && imem_req_ready) begin
          check32("req_addr_aligned", {30'd0, imem_req_addr[1:0]}, 32'd0);
          pending   = 1'b1;
          pend_addr = imem_req_addr;
          pend_cnt  = ((mem_lat == 0) ? int'($urandom_range(1, 3)) : mem_lat) - 1;
          if (!redirect_valid && !halt) req_log.push_back(imem_req_addr);
        end
        prev_wait = imem_req_valid && !imem_req_ready && !redirect_valid && !halt;
        prev_addr = imem_req_addr;
      end
    end
  end

  // Decode model.
  initial begin
    inst_ready = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      case (dec_mode)
        0:       inst_ready = 1'b1;
        1:       inst_ready = 1'b0;
        default: inst_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: every accepted instruction is compared to the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (reset && inst_valid && inst_ready && !redirect_valid && !halt) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_inst: got pc %h, expected no instruction", inst_pc);
        end else begin
          e = exp_q.pop_front();
          check32("inst_pc", inst_pc, e.pc);
          check32("inst_word", inst, e.word);
          consumed++;
          cons_log.push_back(inst_pc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    halt           = 1'b0;
    gen_pc         = RPC;

    // Straight-line fetch, memory always ready, one-cycle response.
    mem_rdy_rand = 1'b0; mem_lat = 1; dec_mode = 0;
    do_reset(1'b1);
    base = cons_log.size();
    step(20);
    for (int i = 0; i < 4; i++) check_cons(base + i, RPC + 32'(4 * i), "seq_pc");

    // Decode stalled: buffer fills with exactly two entries.
    dec_mode = 1;
    do_reset(1'b0);
    rb = req_log.size();
    step(10);
    #3;
    check32("stall_req_count", 32'(req_log.size() - rb), 32'd2);
    check32("stall_inst_valid", {31'd0, inst_valid}, 32'd1);
    check32("stall_inst_pc", inst_pc, RPC);
    check32("stall_inst_word", inst, mem_word(RPC));
    dec_mode = 0;
    step(8);
    check32("third_req_after_pop", {31'd0, (req_log.size() - rb) > 2}, 32'd1);

    // Redirect while waiting on the response for address 8.
    mem_lat = 2;
    do_reset(1'b0);
    rb = req_log.size();
    wait_req_addr(32'h8, rb, 60);
    redirect_now(32'h103);
    rb2 = req_log.size();
    #3;
    check32("drain_no_req", {31'd0, imem_req_valid}, 32'd0);
    base = cons_log.size();
    step(15);
    check_req(rb2, 32'h100, "redirect_req_addr");
    check_cons(base, 32'h100, "redirect_inst_pc");

    // Address wrap at the top of the address space.
    mem_lat = 1;
    step(5);
    redirect_now(32'hFFFF_FFFE);
    rb = req_log.size();
    base = cons_log.size();
    step(12);
    check_req(rb, 32'hFFFF_FFFC, "wrap_req0");
    check_req(rb + 1, 32'h0000_0000, "wrap_req1");
    check_cons(base, 32'hFFFF_FFFC, "wrap_pc0");
    check_cons(base + 1, 32'h0000_0000, "wrap_pc1");

    // Random traffic with random redirects.
    mem_rdy_rand = 1'b1; mem_lat = 0; dec_mode = 2;
    c0 = consumed;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      topup();
      if ($urandom_range(0, 24) == 0) begin
        rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                          : 32'($urandom);
        redirect_now(rpc);
      end
    end
    check32("random_progress", {31'd0, (consumed - c0) > 20}, 32'd1);

    // Halt together with redirect: halt wins, nothing more is fetched.
    mem_rdy_rand = 1'b0; mem_lat = 1; dec_mode = 0;
    step(6);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    halt           = 1'b1;
    halted_model   = 1'b1;
    exp_q.delete();
    @(negedge clk);
    redirect_valid = 1'b0;
    halt           = 1'b0;
    rb = req_log.size();
    for (int c = 0; c < 15; c++) begin
      #3;
      check32("halted_flag", {31'd0, is_halted}, 32'd1);
      check32("halted_no_req", {31'd0, imem_req_valid}, 32'd0);
      check32("halted_no_inst", {31'd0, inst_valid}, 32'd0);
      @(negedge clk);
      redirect_valid = ($urandom_range(0, 1) == 1);
      redirect_pc    = 32'($urandom);
    end
    redirect_valid = 1'b0;
    check32("halted_req_count", 32'(req_log.size() - rb), 32'd0);

    // Reset pulse mid-transaction with a stale response after release.
    mem_lat = 3;
    do_reset(1'b0);
    rb = req_log.size();
    wait_req_addr(32'h4, rb, 60);
    keep_stale = 1'b1;
    reset      = 1'b0;
    exp_q.delete();
    gen_pc = RPC;
    topup();
    @(negedge clk);
    reset = 1'b1;
    topup();
    base = cons_log.size();
    @(negedge clk);
    keep_stale = 1'b0;
    topup();
    step(20);
    check_cons(base, RPC, "post_reset_pc0");
    check_cons(base + 1, RPC + 32'd4, "post_reset_pc1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter: BUF_DEPTH, default 2, instruction buffer entries; only 2 is supported.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low; asserted when 0.
REQ-005 imem_req_valid  output  1  fetch request to instruction memory.
REQ-006 imem_req_addr  output  32  word-aligned fetch address; bits[1:0] always 00.
REQ-007 imem_req_ready  input  1  memory accepts request this cycle.
REQ-008 imem_resp_valid  input  1  instruction word returned this cycle.
REQ-009 imem_resp_data  input  32  returned instruction word.
REQ-010 inst_valid  output  1  buffer head valid toward decode/ControlUnit.
REQ-011 inst  output  32  buffer head instruction (part_of_inst source).
REQ-012 inst_pc  output  32  PC of buffer head.
REQ-013 inst_ready  input  1  decode consumes head this cycle.
REQ-014 redirect_valid  input  1  taken branch/jal/jalr; flush and refetch.
REQ-015 redirect_pc  input  32  redirect target; bits[1:0] ignored, treated as 00.
REQ-016 halt  input  1  ecall termination; stop fetching permanently until reset.
REQ-017 is_halted  output  1  high in HALTED state.

Function
REQ-018 States SHALL be IDLE, WAIT_RESP, DRAIN, HALTED; encoding free.
REQ-019 At most one memory request SHALL be outstanding.
REQ-020 Request handshake: transfer when imem_req_valid && imem_req_ready; imem_req_valid and imem_req_addr SHALL hold stable until transfer.
REQ-021 IDLE: imem_req_valid=1 iff buffer count < 2 and no redirect/halt this cycle; on transfer -> WAIT_RESP, fetch_pc += 4 (mod 2^32, wrap from FFFF_FFFC to 0).
REQ-022 WAIT_RESP: imem_req_valid=0; on imem_resp_valid write {fetch_pc_of_req, imem_resp_data} to buffer tail -> IDLE.
REQ-023 Response arriving same cycle as inst_ready on a full buffer SHALL succeed (pop and push together); count unchanged.
REQ-024 Buffer count SHALL never exceed 2; request is not issued if a response could overflow it.
REQ-025 inst_valid = (count != 0); inst/inst_pc = head entry; pop when inst_valid && inst_ready.
REQ-026 inst_ready with empty buffer SHALL have no effect.
REQ-027 Redirect (any state except HALTED): buffer flushed (count=0) same edge, fetch_pc = {redirect_pc[31:2],2'b00}; any concurrent pop or push ignored.
REQ-028 Redirect in IDLE -> IDLE; new request issued earliest next cycle.
REQ-029 Redirect in WAIT_RESP without same-cycle response -> DRAIN; with same-cycle response -> IDLE, response discarded.
REQ-030 DRAIN: imem_req_valid=0; next imem_resp_valid discarded -> IDLE; further redirect in DRAIN updates fetch_pc, stays DRAIN.
REQ-031 Redirect during a request not yet accepted SHALL drop that request; address changes next cycle.
REQ-032 halt (any state) -> HALTED; buffer flushed; halt wins over simultaneous redirect.
REQ-033 HALTED: imem_req_valid=0, inst_valid=0, is_halted=1; all inputs ignored; late responses discarded.
REQ-034 Fetch-to-inst_valid latency SHALL be: response cycle +1 (registered buffer); no combinational path imem_resp_* -> inst_*.
REQ-035 No combinational path from inst_ready or redirect_valid to imem_req_valid.

Reset
REQ-036 While reset=0: state=IDLE, fetch_pc=RESET_PC, count=0, buffer pointers=0, is_halted=0, inst_valid=0, imem_req_valid=0.
REQ-037 After reset deasserts, first request (addr RESET_PC) SHALL assert on the first clock edge's following cycle.
REQ-038 Reset asserted mid-transaction SHALL abandon it immediately; a stale response after reset release while in IDLE SHALL be ignored.

Verification
REQ-039 Reset, memory always ready, 1-cycle response, inst_ready=1 -> inst_pc sequence 0,4,8,C; inst matches memory image.
REQ-040 inst_ready=0 for 10 cycles -> exactly 2 requests (0,4), inst_valid stays 1 at pc 0, no third request until pop.
REQ-041 redirect_pc=0x103 during WAIT_RESP for addr 8 -> DRAIN, response for 8 dropped, next request 0x100, next inst_pc 0x100.
REQ-042 redirect and halt same cycle -> is_halted=1, no further requests, inst_valid=0 until reset.
REQ-043 fetch_pc=FFFF_FFFC -> request FFFF_FFFC then 0000_0000.
REQ-044 reset pulse while WAIT_RESP, response arrives after release -> response discarded, first delivered inst_pc=RESET_PC.
